instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter RESET_PC SHALL default to 32'h0000_0000 and SHALL give the PC value loaded on reset.
REQ-003 Port clk SHALL be input, 1 bit: the system clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: asynchronous, active-high reset.
REQ-005 Port imem_req SHALL be output, 1 bit: instruction-memory read request.
REQ-006 Port imem_addr SHALL be output, 32 bits: word-aligned fetch address.
REQ-007 Port imem_ack SHALL be input, 1 bit: read data valid; sampled only while imem_req=1.
REQ-008 Port imem_rdata SHALL be input, 32 bits: fetched instruction word.
REQ-009 Port Instr SHALL be output, 32 bits: held instruction presented to decode.
REQ-010 Port OP_Code SHALL be output, 6 bits: always equal to Instr[31:26].
REQ-011 Port instr_valid SHALL be output, 1 bit: Instr/OP_Code are valid.
REQ-012 Port instr_ready SHALL be input, 1 bit: decode/datapath consumes Instr this cycle.
REQ-013 Ports Jump, Branch and Zero SHALL be inputs, 1 bit each: control-unit decode of Instr, plus the ALU zero flag; sampled only on accept.
REQ-014 Port pc_out SHALL be output, 32 bits: address of the currently held Instr.

Function
REQ-015 The FSM SHALL have three states: FETCH (imem_req=1), HOLD (instr_valid=1) and an internal RESET state; RESET SHALL move to FETCH on the first clock after rst deasserts.
REQ-016 In FETCH, imem_addr SHALL equal PC and SHALL stay stable until imem_ack; ack in cycle N SHALL capture imem_rdata into Instr, set pc_out=PC, and move the FSM to HOLD, so instr_valid=1 in cycle N+1.
REQ-017 imem_ack may assert in the first request cycle; the minimum fetch-to-fetch period SHALL be 2 cycles.
REQ-018 In HOLD, Instr, OP_Code and pc_out SHALL stay stable until accept, where accept = instr_valid & instr_ready.
REQ-019 On accept, next PC SHALL be selected as follows: Jump=1 gives {pc_out+4}[31:28],Instr[25:0],2'b00; else Branch&Zero gives pc_out+4+(sign_ext(Instr[15:0])<<2); else pc_out+4. The FSM SHALL then return to FETCH, with the new imem_req in the next cycle.
REQ-020 Jump SHALL have priority when Jump and Branch are both 1.
REQ-021 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
REQ-022 PC[1:0] SHALL always be 00; branch/jump targets are aligned by construction.
REQ-023 The block SHALL allow at most one outstanding request, and imem_ack outside FETCH SHALL be ignored.

Reset
REQ-024 While rst=1: imem_req=0, instr_valid=0, imem_addr=RESET_PC, PC=RESET_PC, Instr=0, OP_Code=0, pc_out=RESET_PC, and any pending delay-slot redirect SHALL be cleared.
REQ-025 Reset asserted during an outstanding request SHALL drop the request immediately, and the late ack SHALL be discarded.

Configuration
REQ-026 Macro IFU_DELAY_SLOT_EN defined: a taken redirect on accept SHALL store its target as pending and fetch pc_out+4 (the delay slot); on accept of the slot, PC SHALL load the pending target and the pending flag SHALL clear.
REQ-027 With IFU_DELAY_SLOT_EN defined, a taken Jump or Branch accepted while the pending flag is set SHALL be ignored.
REQ-028 Macro IFU_DELAY_SLOT_EN undefined: a taken redirect SHALL load PC with the target immediately, and no pending state SHALL exist.

Structure
REQ-029 Shared package cpu_pkg SHALL hold the opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010), the default RESET_PC, and the fetch-state enum.
REQ-030 Next-PC selection SHALL be a combinational sub-module pc_next_calc (inputs pc, instr, Jump, Branch, Zero; output next_pc).

Verification
REQ-031 Reset release with imem_ack tied high and instr_ready high -> addresses 0x0,0x4,0x8 issued on alternate cycles.
REQ-032 Instr 0x08000010 (j), Jump=1 accepted at pc 0x0 -> next imem_addr 0x40 (undefined macro), or 0x4 then 0x40 (macro defined).
REQ-033 beq at pc 0x100, imm 0xFFFF, Branch=1 Zero=1 -> next address 0x100; same with Zero=0 -> 0x104.
REQ-034 instr_ready held low 5 cycles in HOLD -> Instr/pc_out constant, imem_req=0 throughout.
REQ-035 imem_ack delayed 3 cycles -> imem_addr stable for 4 cycles; rst pulsed mid-wait, then late ack -> ack ignored, refetch from RESET_PC.
REQ-036 PC 0xFFFF_FFFC sequential accept -> next imem_addr 0x0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, default reset PC and fetch FSM states.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StReset,
        StFetch,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: one request at a time, ack carries the read data.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for an accepted instruction: jump, taken branch or sequential.
module pc_next_calc (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic        unused_opcode;

    assign pc_plus4      = pc + 32'd4;
    assign br_off        = {{14{instr[15]}}, instr[15:0], 2'b00};
    // Opcode field is decoded by the control unit, not here.
    assign unused_opcode = ^instr[31:26];

    // Jump wins over branch; all sums wrap modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4 + br_off;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word at a time and holds it until decode accepts it.
// Optional build macro IFU_DELAY_SLOT_EN enables a single architectural branch delay slot.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               Instr,
    output logic [5:0]                OP_Code,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    input  logic                      Jump,
    input  logic                      Branch,
    input  logic                      Zero,
    output logic [31:0]               pc_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  next_pc;

`ifdef IFU_DELAY_SLOT_EN
    logic         pending_q, pending_d;
    logic [31:0]  target_q, target_d;
    logic         taken;
    logic [31:0]  seq_pc;

    assign taken  = Jump | (Branch & Zero);
    assign seq_pc = pc_out_q + 32'd4;
`endif

    pc_next_calc u_pc_next_calc (
        .pc      (pc_out_q),
        .instr   (instr_q),
        .Jump    (Jump),
        .Branch  (Branch),
        .Zero    (Zero),
        .next_pc (next_pc)
    );

    assign imem.imem_addr = pc_q;
    assign Instr          = instr_q;
    assign OP_Code        = instr_q[31:26];
    assign pc_out         = pc_out_q;

    // Next-state logic: request in FETCH, present instruction in HOLD, redirect on accept.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        instr_d          = instr_q;
        pc_out_d         = pc_out_q;
        imem.imem_req    = 1'b0;
        instr_valid      = 1'b0;
`ifdef IFU_DELAY_SLOT_EN
        pending_d        = pending_q;
        target_d         = target_q;
`endif
        unique case (state_q)
            StReset: begin
                state_d = StFetch;
            end
            StFetch: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    instr_d  = imem.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = StHold;
                end
            end
            StHold: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_d = StFetch;
`ifdef IFU_DELAY_SLOT_EN
                    // Slot instruction consumed: go to the saved target, ignore its own redirect.
                    if (pending_q) begin
                        pc_d      = target_q;
                        pending_d = 1'b0;
                    end else if (taken) begin
                        target_d  = next_pc;
                        pending_d = 1'b1;
                        pc_d      = seq_pc;
                    end else begin
                        pc_d      = next_pc;
                    end
`else
                    pc_d = next_pc;
`endif
                end
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    // State registers; reset drops any outstanding request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReset;
            pc_q      <= {RESET_PC[31:2], 2'b00};
            instr_q   <= 32'h0;
            pc_out_q  <= {RESET_PC[31:2], 2'b00};
`ifdef IFU_DELAY_SLOT_EN
            pending_q <= 1'b0;
            target_q  <= 32'h0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= {pc_d[31:2], 2'b00};
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
`ifdef IFU_DELAY_SLOT_EN
            pending_q <= pending_d;
            target_q  <= target_d;
`endif
        end
    end

endmodule
